master_spi_tx_ctrl: RTL and testbench

MASTER_SPI_TX_CTRL -- requirements
Module: master_spi_tx_ctrl

---
 rtl/master_spi_pkg.sv | 25 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/master_spi_tx_ctrl.sv | 117 +++++++++++
 tb/tb_master_spi_tx_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/master_spi_pkg.sv
// Shared SPI master definitions: FSM encoding and SCLK mode constants,
// common to the tx controller and the rx stage.
package master_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    // Mode constants packed as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam logic [4:0] SPI_EDGES = 5'd16;

    // SCLK level reached on a data-sampling edge for the given mode
    function automatic logic sample_level(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period tick generator: counts 0..CLK_DIV-1 while enabled and
// pulses tick_o on the last count; held at zero while disabled.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (!en_i || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick_o = en_i && (r_cnt == LAST);

endmodule

// File: rtl/master_spi_tx_ctrl.sv
// SPI master transmit controller: frames one byte MSB-first on MOSI with
// configurable CPOL/CPHA and SCLK half-period of CLK_DIV system clocks.
module master_spi_tx_ctrl
    import master_spi_pkg::*;
#(
    parameter logic CPOL    = 1'b0,
    parameter logic CPHA    = 1'b0,
    parameter int   CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       spi_tx_req,
    input  logic [7:0] spi_tx_i,
    output logic       spi_busy_o,
    output logic       spi_tx_done,
    output logic       spi_clk_o,
    output logic       spi_en_o,
    output logic       spi_tx_o,
    output logic [1:0] dbg_state_o
);

    // Handshake: spi_tx_req is a start pulse honoured only in IDLE; busy and
    // en rise the cycle after acceptance and drop the cycle after spi_tx_done.
    spi_state_e r_state, w_next;
    logic [4:0] r_edge;
    logic [7:0] r_shift;
    logic       r_sclk;
    logic       r_mosi;
    logic       w_tick;
    logic       w_accept;
    logic       w_div_en;
    logic [4:0] w_edge_num;
    logic       w_last_edge;
    logic       w_shift_edge;
    logic       w_done;

    assign w_div_en = (r_state != ST_IDLE);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (w_div_en),
        .tick_o  (w_tick)
    );

    assign w_edge_num  = r_edge + 5'd1;
    assign w_last_edge = (w_edge_num == SPI_EDGES);
    // CPHA=0 launches on even edges (bit7 already out from SETUP), CPHA=1 on odd
    assign w_shift_edge = (r_state == ST_SHIFT) && w_tick
                          && (w_edge_num[0] == CPHA) && !w_last_edge;
    assign w_done = (r_state == ST_HOLD) && w_tick;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (spi_tx_req) begin
                    w_next   = ST_SETUP;
                    w_accept = 1'b1;
                end
            end
            ST_SETUP: if (w_tick) w_next = ST_SHIFT;
            ST_SHIFT: if (w_tick && w_last_edge) w_next = ST_HOLD;
            ST_HOLD:  if (w_tick) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_edge <= 5'd0;
            r_sclk <= CPOL;
        end else if (r_state == ST_SHIFT) begin
            if (w_tick) begin
                r_edge <= w_edge_num;
                r_sclk <= ~r_sclk;
            end
        end else begin
            r_sclk <= CPOL;
            if (r_state == ST_IDLE) r_edge <= 5'd0;
        end
    end

    // The shift register holds the bits not yet presented on MOSI
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_shift <= 8'd0;
            r_mosi  <= 1'b0;
        end else if (w_accept) begin
            r_shift <= CPHA ? spi_tx_i : {spi_tx_i[6:0], 1'b0};
            r_mosi  <= CPHA ? 1'b0 : spi_tx_i[7];
        end else if ((r_state == ST_IDLE) || w_done) begin
            r_shift <= 8'd0;
            r_mosi  <= 1'b0;
        end else if (w_shift_edge) begin
            r_mosi  <= r_shift[7];
            r_shift <= {r_shift[6:0], 1'b0};
        end
    end

    assign spi_busy_o  = (r_state != ST_IDLE);
    assign spi_en_o    = (r_state != ST_IDLE);
    assign spi_tx_done = w_done;
    assign spi_clk_o   = r_sclk;
    assign spi_tx_o    = r_mosi;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_master_spi_tx_ctrl.sv
// Directed bench for master_spi_tx_ctrl: five instances covering the four SPI
// modes and CLK_DIV of 1..4, each with a bus monitor acting as receiver.
module tb_master_spi_tx_ctrl;

    localparam int N = 5;
    // Instance g: 0 mode0/div4, 1 mode1/div2, 2 mode2/div3, 3 mode3/div2, 4 mode0/div1
    localparam bit [N-1:0] P_CPOL = 5'b01100;
    localparam bit [N-1:0] P_CPHA = 5'b01010;
    // SCLK level after a sampling edge: rising for modes 0/3, falling for 1/2
    localparam bit [N-1:0] P_SAMP = 5'b11001;

    function automatic int div_of(input int g);
        case (g)
            0: return 4;
            1: return 2;
            2: return 3;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [7:0]     tx_data [N];
    logic [N-1:0]   busy, done, sclk, en, mosi;
    logic [1:0]     dbg_state [N];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        master_spi_tx_ctrl #(
            .CPOL    (P_CPOL[g]),
            .CPHA    (P_CPHA[g]),
            .CLK_DIV (div_of(g))
        ) u_dut (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .spi_tx_req  (req[g]),
            .spi_tx_i    (tx_data[g]),
            .spi_busy_o  (busy[g]),
            .spi_tx_done (done[g]),
            .spi_clk_o   (sclk[g]),
            .spi_en_o    (en[g]),
            .spi_tx_o    (mosi[g]),
            .dbg_state_o (dbg_state[g])
        );

        logic       prev_sclk = P_CPOL[g];
        logic       prev_en   = 1'b0;
        logic       done_prev = 1'b0;
        logic       last_done_ok = 1'b0;
        logic [7:0] sr = 8'd0;
        logic [7:0] rx_byte = 8'd0;
        int bits = 0, rx_bits = 0, edges = 0;
        int en_len = 0, last_len = 0, busy_len = 0, last_busy = 0;
        int gap = 0, last_gap = 0, frames = 0, dones = 0;

        always @(negedge clk) begin
            if (en[g]) begin
                if (!prev_en) begin
                    last_gap = gap;
                    bits = 0;
                    edges = 0;
                    en_len = 0;
                    busy_len = 0;
                end
                en_len++;
                if (sclk[g] != prev_sclk) begin
                    edges++;
                    if (sclk[g] == P_SAMP[g]) begin
                        sr = {sr[6:0], mosi[g]};
                        bits++;
                    end
                end
            end else begin
                if (prev_en) begin
                    last_len = en_len;
                    last_busy = busy_len;
                    rx_byte = sr;
                    rx_bits = bits;
                    last_done_ok = done_prev;
                    frames++;
                    gap = 0;
                end
                gap++;
            end
            if (busy[g]) busy_len++;
            if (done[g]) dones++;
            done_prev = done[g];
            prev_en = en[g];
            prev_sclk = sclk[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input int g, input logic [7:0] d);
        @(negedge clk);
        tx_data[g] = d;
        req[g] = 1'b1;
        @(negedge clk);
        req[g] = 1'b0;
        tx_data[g] = ~d;
    endtask

    task automatic wait_idle(input int g, input int lim);
        int n = 0;
        @(negedge clk);
        while (busy[g] && n < lim) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_within_bound_g%0d", g), {31'd0, busy[g]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int d0, dn;
        for (int g = 0; g < N; g++) tx_data[g] = 8'h00;

        // Reset state while rst_n is low and the clock runs
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++)
            check($sformatf("reset_outputs_g%0d", g),
                  {27'd0, sclk[g], en[g], busy[g], done[g], mosi[g]},
                  {27'd0, P_CPOL[g], 4'b0000});
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state_idle", {30'd0, dbg_state[0]}, 32'd0);

        // Mode 0, div 4, 8'hA5
        send(0, 8'hA5);
        check("accept_en_busy", {30'd0, en[0], busy[0]}, 32'd3);
        check("setup_mosi_bit7", {31'd0, mosi[0]}, 32'd1);
        check("setup_sclk_idle", {31'd0, sclk[0]}, 32'd0);
        wait_idle(0, 200);
        check("m0_rx_a5", {24'd0, g_dut[0].rx_byte}, 32'h A5);
        check("m0_en_len", g_dut[0].last_len, 72);
        check("m0_done_count", g_dut[0].dones, 1);
        check("m0_done_last_cycle", {31'd0, g_dut[0].last_done_ok}, 32'd1);
        check("idle_mosi_zero", {31'd0, mosi[0]}, 32'd0);

        // Loopback 8'h5A in all four modes
        send(0, 8'h5A);
        send(1, 8'h5A);
        send(2, 8'h5A);
        send(3, 8'h5A);
        for (int g = 0; g < 4; g++) wait_idle(g, 200);
        check("lb_rx_g0", {24'd0, g_dut[0].rx_byte}, 32'h5A);
        check("lb_rx_g1", {24'd0, g_dut[1].rx_byte}, 32'h5A);
        check("lb_rx_g2", {24'd0, g_dut[2].rx_byte}, 32'h5A);
        check("lb_rx_g3", {24'd0, g_dut[3].rx_byte}, 32'h5A);
        check("lb_bits_g1", g_dut[1].rx_bits, 8);
        check("lb_bits_g2", g_dut[2].rx_bits, 8);
        check("lb_len_g1", g_dut[1].last_len, 36);
        check("lb_len_g2", g_dut[2].last_len, 54);
        check("lb_len_g3", g_dut[3].last_len, 36);
        check("lb_done_g1", {31'd0, g_dut[1].last_done_ok}, 32'd1);
        check("lb_done_g2", {31'd0, g_dut[2].last_done_ok}, 32'd1);
        check("lb_done_g3", {31'd0, g_dut[3].last_done_ok}, 32'd1);

        // Mode 3, div 2, 8'h3C: SCLK idles high
        send(3, 8'h3C);
        wait_idle(3, 100);
        check("m3_rx_3c", {24'd0, g_dut[3].rx_byte}, 32'h3C);
        check("m3_sclk_idle_high", {31'd0, sclk[3]}, 32'd1);
        check("m3_edges", g_dut[3].edges, 16);

        // Request issued mid-frame is ignored
        d0 = g_dut[0].frames;
        send(0, 8'hC3);
        repeat (8) @(negedge clk);
        send(0, 8'h11);
        wait_idle(0, 200);
        repeat (20) @(negedge clk);
        check("midreq_one_frame", g_dut[0].frames, d0 + 1);
        check("midreq_rx_c3", {24'd0, g_dut[0].rx_byte}, 32'hC3);
        check("midreq_busy_len", g_dut[0].last_busy, 72);
        check("midreq_no_queue", {31'd0, busy[0]}, 32'd0);

        // Reset during SHIFT edge 7 aborts the frame
        dn = g_dut[0].dones;
        send(0, 8'h3F);
        begin
            int n = 0;
            while (g_dut[0].edges != 7 && n < 200) begin
                @(posedge clk);
                n++;
            end
        end
        check("abort_edge7_reached", g_dut[0].edges, 7);
        check("abort_sclk_high_before", {31'd0, sclk[0]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_en_low", {31'd0, en[0]}, 32'd0);
        check("abort_sclk_cpol", {31'd0, sclk[0]}, 32'd0);
        check("abort_mosi_busy_done", {29'd0, mosi[0], busy[0], done[0]}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", g_dut[0].dones, dn);
        send(0, 8'h96);
        wait_idle(0, 200);
        check("post_reset_rx_96", {24'd0, g_dut[0].rx_byte}, 32'h96);
        check("post_reset_len", g_dut[0].last_len, 72);
        check("post_reset_done", g_dut[0].dones, dn + 1);

        // Div 1 back-to-back: 8'hFF, then 8'h00 in the first idle cycle
        send(4, 8'hFF);
        begin
            int n = 0;
            while (!done[4] && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        check("b2b_done_seen", {31'd0, done[4]}, 32'd1);
        @(negedge clk);
        check("b2b_idle_cycle", {30'd0, en[4], busy[4]}, 32'd0);
        tx_data[4] = 8'h00;
        req[4] = 1'b1;
        @(negedge clk);
        req[4] = 1'b0;
        tx_data[4] = 8'hA7;
        check("b2b_second_accepted", {31'd0, en[4]}, 32'd1);
        check("b2b_first_rx_ff", {24'd0, g_dut[4].rx_byte}, 32'hFF);
        check("b2b_first_len", g_dut[4].last_len, 18);
        wait_idle(4, 50);
        check("b2b_second_rx_00", {24'd0, g_dut[4].rx_byte}, 32'h00);
        check("b2b_second_len", g_dut[4].last_len, 18);
        check("b2b_gap", g_dut[4].last_gap, 1);
        check("b2b_done_count", g_dut[4].dones, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
